// File: rtl/booth_pkg.sv
// booth_pkg: shared constants and types for the Booth multiply scheduler.
//   WIDTH           operand width (32 only)
//   N_STEPS         Booth iterations per multiply (equals WIDTH)
//   STEPS_PER_CYCLE 1 by default, 2 when BOOTH_DUAL_STEP_EN is defined
//   CNT_W           width of the iteration counter (must hold N_STEPS)
//   state_t         scheduler FSM encoding
// Build option: BOOTH_DUAL_STEP_EN selects two chained substeps per cycle.
package booth_pkg;
  localparam int WIDTH   = 32;
  localparam int N_STEPS = 32;
`ifdef BOOTH_DUAL_STEP_EN
  localparam int STEPS_PER_CYCLE = 2;
`else
  localparam int STEPS_PER_CYCLE = 1;
`endif
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/booth_mul_sched_if.sv
// booth_mul_sched_if: request and result bundle of the Booth scheduler.
//   req_valid/req_ready   per-requester request handshake ([i] = requester i)
//   req_mcand/req_mplier  operands, requester i on bits [i*WIDTH +: WIDTH]
//   res_valid/res_ready   product handshake
//   res_product/res_id    signed product {acc,Q} and owning requester
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high; a source keeps valid and its data
// stable until that edge; ready may depend combinationally on valid.
// master = requesters and result consumer, slave = the scheduler.
interface booth_mul_sched_if;
  import booth_pkg::*;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_mcand;
  logic [2*WIDTH-1:0] req_mplier;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_product;
  logic               res_id;

  modport master (
    output req_valid, req_mcand, req_mplier, res_ready,
    input  req_ready, res_valid, res_product, res_id
  );

  modport slave (
    input  req_valid, req_mcand, req_mplier, res_ready,
    output req_ready, res_valid, res_product, res_id
  );
endinterface

// File: rtl/booth_substep.sv
// booth_substep: one combinational radix-2 Booth iteration.
//   acc, q, q_m1, mcand   current accumulator, multiplier register, q[-1]
//   next_acc, next_q      values after add/sub and arithmetic right shift
//   q0_next               new q[-1] (the bit shifted out of q)
module booth_substep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] next_acc,
  output logic [WIDTH-1:0] next_q,
  output logic             q0_next
);
  // One guard bit keeps the add/sub exact (e.g. 0 - (-2^31)); after the
  // right shift the result always fits back into WIDTH bits.
  logic [WIDTH:0] acc_x;
  logic [WIDTH:0] mcand_x;
  logic [WIDTH:0] sum;

  always_comb begin
    acc_x   = {acc[WIDTH-1], acc};
    mcand_x = {mcand[WIDTH-1], mcand};
    sum     = acc_x;
    case ({q[0], q_m1})
      2'b01:   sum = acc_x + mcand_x;
      2'b10:   sum = acc_x - mcand_x;
      default: sum = acc_x;
    endcase
    next_acc = sum[WIDTH:1];
    next_q   = {sum[0], q[WIDTH-1:1]};
    q0_next  = q[0];
  end
endmodule

// File: rtl/booth_mul_sched.sv
// booth_mul_sched: round-robin front end and sequencer for the iterative
// Booth datapath. Grants one of two requesters, runs N_STEPS Booth
// iterations, then holds the 64-bit signed product until it is accepted.
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         booth_mul_sched_if.slave (request/result channels)
//   busy        high in every state except IDLE
//   state_dbg   current FSM state
// Build option: BOOTH_DUAL_STEP_EN chains two substeps, halving RUN length.
module booth_mul_sched #(
  parameter int WIDTH   = booth_pkg::WIDTH,
  parameter int N_STEPS = booth_pkg::N_STEPS
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_mul_sched_if.slave  bus,
  output logic              busy,
  output booth_pkg::state_t state_dbg
);
  import booth_pkg::*;

  localparam logic [CNT_W-1:0] STEP_INC = CNT_W'(STEPS_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_STEPS - STEPS_PER_CYCLE);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] step_cnt;
  logic             rr_ptr;
  logic             id;
  logic             res_valid_r;

  logic [WIDTH-1:0] s_acc;
  logic [WIDTH-1:0] s_q;
  logic             s_q0;

`ifdef BOOTH_DUAL_STEP_EN
  logic [WIDTH-1:0] m_acc;
  logic [WIDTH-1:0] m_q;
  logic             m_q0;

  booth_substep #(.WIDTH(WIDTH)) u_step0 (
    .acc(acc), .q(q), .q_m1(q_m1), .mcand(mcand),
    .next_acc(m_acc), .next_q(m_q), .q0_next(m_q0)
  );
  booth_substep #(.WIDTH(WIDTH)) u_step1 (
    .acc(m_acc), .q(m_q), .q_m1(m_q0), .mcand(mcand),
    .next_acc(s_acc), .next_q(s_q), .q0_next(s_q0)
  );
`else
  booth_substep #(.WIDTH(WIDTH)) u_step0 (
    .acc(acc), .q(q), .q_m1(q_m1), .mcand(mcand),
    .next_acc(s_acc), .next_q(s_q), .q0_next(s_q0)
  );
`endif

  // Arbiter: only grants in IDLE; a tie goes to rr_ptr.
  logic       grant_id;
  logic [1:0] grant;

  always_comb begin
    grant    = 2'b00;
    grant_id = (bus.req_valid == 2'b11) ? rr_ptr : bus.req_valid[1];
    if (state == IDLE && bus.req_valid != 2'b00) begin
      grant[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
      mcand       <= '0;
      step_cnt    <= '0;
      rr_ptr      <= 1'b0;
      id          <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            acc      <= '0;
            q        <= grant_id ? bus.req_mplier[2*WIDTH-1:WIDTH] : bus.req_mplier[WIDTH-1:0];
            mcand    <= grant_id ? bus.req_mcand[2*WIDTH-1:WIDTH]  : bus.req_mcand[WIDTH-1:0];
            q_m1     <= 1'b0;
            id       <= grant_id;
            step_cnt <= '0;
            rr_ptr   <= ~grant_id;
            state    <= RUN;
          end
        end
        RUN: begin
          acc      <= s_acc;
          q        <= s_q;
          q_m1     <= s_q0;
          step_cnt <= step_cnt + STEP_INC;
          if (step_cnt == LAST_CNT) begin
            res_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; the next grant needs a fresh IDLE cycle.
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = grant;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_product = {acc, q};
  assign bus.res_id      = id;
  assign busy            = (state != IDLE);
  assign state_dbg       = state;
endmodule

// File: tb/tb_booth_mul_sched.sv
// tb_booth_mul_sched: directed + randomized bench for booth_mul_sched.
// Expected products come from plain 64-bit signed multiplication.
module tb_booth_mul_sched;
  import booth_pkg::*;

  localparam int EXP_LAT = N_STEPS / STEPS_PER_CYCLE + 1;
  localparam int BOUND   = 200;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_t state_dbg;

  always #5 clk = ~clk;

  booth_mul_sched_if bus ();

  booth_mul_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic        exp_id_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ops(input logic rid, input logic [31:0] a, input logic [31:0] b);
    if (rid) begin
      bus.req_mcand[63:32]  = a;
      bus.req_mplier[63:32] = b;
    end else begin
      bus.req_mcand[31:0]   = a;
      bus.req_mplier[31:0]  = b;
    end
  endtask

  // Issue one request from an idle DUT and check grant, latency, product, id.
  task automatic do_mul(input logic rid, input logic [31:0] a, input logic [31:0] b);
    int cnt;
    @(posedge clk); #1;
    set_ops(rid, a, b);
    bus.req_valid = rid ? 2'b10 : 2'b01;
    @(negedge clk);
    check("grant", 64'(bus.req_ready), rid ? 64'd2 : 64'd1);
    exp_q.push_back(ref_mul(a, b));
    exp_id_q.push_back(rid);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.res_valid && cnt < BOUND);
    check("latency", 64'(cnt), 64'(EXP_LAT));
    check("product", bus.res_product, exp_q.pop_front());
    check("res_id", 64'(bus.res_id), 64'(exp_id_q.pop_front()));
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("idle_after_accept", {62'd0, bus.res_valid, busy}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          cnt;
    int          hits;
    logic [1:0]  exp_g;
    logic        w;
    logic [63:0] held;

    bus.req_valid  = 2'b00;
    bus.req_mcand  = '0;
    bus.req_mplier = '0;
    bus.res_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", bus.res_product, 64'd0);
    check("rst_res_id", 64'(bus.res_id), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin: both requesters keep requesting, operands refreshed after grants
    @(posedge clk); #1;
    set_ops(1'b0, $urandom, $urandom);
    set_ops(1'b1, $urandom, $urandom);
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      exp_g = (g == 1) ? 2'b10 : 2'b01;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (bus.req_ready == 2'b00 && cnt < BOUND);
      check("rr_grant", 64'(bus.req_ready), 64'(exp_g));
      w = exp_g[1];
      exp_q.push_back(w ? ref_mul(bus.req_mcand[63:32], bus.req_mplier[63:32])
                        : ref_mul(bus.req_mcand[31:0], bus.req_mplier[31:0]));
      exp_id_q.push_back(w);
      @(posedge clk); #1;
      set_ops(w, $urandom, $urandom);
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus.res_valid && cnt < BOUND);
      check("rr_product", bus.res_product, exp_q.pop_front());
      check("rr_res_id", 64'(bus.res_id), 64'(exp_id_q.pop_front()));
      check("rr_no_grant_in_done", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b0;

    // res_ready high while idle has no effect
    bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_ready_busy", {62'd0, bus.res_valid, busy}, 64'd0);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;

    // Directed products
    do_mul(1'b0, 32'd3, 32'd5);
    do_mul(1'b1, 32'hFFFF_FFF9, 32'd6);
    do_mul(1'b0, 32'h8000_0000, 32'h8000_0000);
    do_mul(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_mul(1'b1, 32'h0, 32'h8000_0000);

    // Randomized products
    for (int k = 0; k < 8; k++) begin
      do_mul(1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    // Hold result for 10 cycles with the other requester pending
    @(posedge clk); #1;
    set_ops(1'b0, 32'h1234_5678, 32'hFEDC_BA98);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("hold_grant", 64'(bus.req_ready), 64'd1);
    held = ref_mul(32'h1234_5678, 32'hFEDC_BA98);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.res_valid && cnt < BOUND);
    check("hold_latency", 64'(cnt), 64'(EXP_LAT));
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check("hold_valid", 64'(bus.res_valid), 64'd1);
      check("hold_product", bus.res_product, held);
      check("hold_no_grant", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    check("hold_res_id", 64'(bus.res_id), 64'd0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("hold_idle", {62'd0, bus.res_valid, busy}, 64'd0);
    check("hold_state", 64'(state_dbg), 64'(IDLE));
    bus.req_valid = 2'b00;

    // Reset in the middle of RUN
    @(posedge clk); #1;
    set_ops(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("rstmid_grant", 64'(bus.req_ready), 64'd2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_res_valid", 64'(bus.res_valid), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_product", bus.res_product, 64'd0);
    check("rstmid_res_id", 64'(bus.res_id), 64'd0);
    check("rstmid_req_ready", 64'(bus.req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hits = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.res_valid) hits++;
    end
    check("rstmid_no_result", 64'(hits), 64'd0);
    do_mul(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    do_mul(1'b0, 32'hFFFF_FFF9, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
